// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streams pixel columns into a KERNELxKERNEL window and emits one weighted sum per strided window.
// Optional CONV_RELU_EN clamps negative results to zero in the result register.
module conv_stream_engine #(
    parameter int BIT_DEPTH = 8,
    parameter int KERNEL    = 3,
    parameter int IMG_WIDTH = 16,
    parameter int ACC_WIDTH = 2*BIT_DEPTH+5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [1:0]                          stride,
    input  logic                                w_we,
    input  logic [$clog2(KERNEL*KERNEL)-1:0]    w_addr,
    input  logic [BIT_DEPTH-1:0]                w_data,
    input  logic                                in_valid,
    input  logic [KERNEL*BIT_DEPTH-1:0]         in_col,
    output logic                                in_ready,
    output logic                                shift_buffer,
    output logic                                out_valid,
    output logic signed [ACC_WIDTH-1:0]         out_data,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done
);
    localparam int NW = KERNEL*KERNEL;
    localparam int CW = $clog2(IMG_WIDTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state;
    logic [BIT_DEPTH-1:0]         win  [KERNEL][KERNEL];
    logic [BIT_DEPTH-1:0]         nwin [KERNEL][KERNEL];
    logic signed [BIT_DEPTH-1:0]  w    [NW];
    logic [CW-1:0]                col_cnt;
    logic [1:0]                   stride_eff;
    logic [1:0]                   skip;
    logic signed [2*BIT_DEPTH:0]  prod;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         accept;
    logic                         qualify;

    assign in_ready     = (state == RUN) && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign shift_buffer = accept;
    // skip counts down the columns left before the next strided window
    assign qualify      = accept && (col_cnt >= CW'(KERNEL-1)) && (skip == 2'd0);

    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < KERNEL; i++) begin
            for (int j = 0; j < KERNEL; j++) begin
                nwin[i][j] = (j == KERNEL-1) ? in_col[i*BIT_DEPTH +: BIT_DEPTH] : win[i][(j+1)%KERNEL];
                prod = $signed({1'b0, nwin[i][j]}) * w[i*KERNEL+j];
                sum  = sum + ACC_WIDTH'(prod);
            end
        end
    end

    // weights deliberately keep their value across reset
    always_ff @(posedge clk) begin
        if (w_we && state == IDLE && int'(w_addr) < NW)
            w[w_addr] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            col_cnt    <= '0;
            stride_eff <= 2'd1;
            skip       <= 2'd0;
            for (int i = 0; i < KERNEL; i++)
                for (int j = 0; j < KERNEL; j++)
                    win[i][j] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= RUN;
                    busy       <= 1'b1;
                    stride_eff <= (stride == 2'd0) ? 2'd1 : stride;
                    col_cnt    <= '0;
                    skip       <= 2'd0;
                    for (int i = 0; i < KERNEL; i++)
                        for (int j = 0; j < KERNEL; j++)
                            win[i][j] <= '0;
                end
                RUN: if (accept && col_cnt == CW'(IMG_WIDTH-1))
                    state <= DRAIN;
                DRAIN: if (!out_valid || out_ready) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
            if (accept) begin
                win     <= nwin;
                col_cnt <= col_cnt + 1'b1;
                if (col_cnt >= CW'(KERNEL-1))
                    skip <= (skip == 2'd0) ? stride_eff - 2'd1 : skip - 2'd1;
            end
            if (qualify) begin
                out_valid <= 1'b1;
`ifdef CONV_RELU_EN
                out_data  <= sum[ACC_WIDTH-1] ? '0 : sum;
`else
                out_data  <= sum;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine: directed rows with a queue scoreboard checked by an independent output monitor.
module tb_conv_stream_engine;
    localparam int BD = 8;
    localparam int K  = 3;
    localparam int IW = 16;
    localparam int AW = 2*BD+5;

    logic                 clk = 1'b0;
    logic                 rst, start, w_we, in_valid, out_ready;
    logic [1:0]           stride;
    logic [3:0]           w_addr;
    logic [BD-1:0]        w_data;
    logic [K*BD-1:0]      in_col;
    logic                 in_ready, shift_buffer, out_valid, busy, done;
    logic signed [AW-1:0] out_data;

    int checks = 0, errors = 0, done_cnt = 0;
    longint expq[$];
    logic hold = 1'b0;
    logic signed [AW-1:0] held;

    conv_stream_engine #(.BIT_DEPTH(BD), .KERNEL(K), .IMG_WIDTH(IW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride), .w_we(w_we), .w_addr(w_addr),
        .w_data(w_data), .in_valid(in_valid), .in_col(in_col), .in_ready(in_ready),
        .shift_buffer(shift_buffer), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold && out_valid)
                chk("hold_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %0d expected no output at %0t", out_data, $time);
                end else begin
                    chk("out_data", out_data, expq.pop_front());
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (done) done_cnt++;
        end
    end

    task automatic load_w(input logic [BD-1:0] v, input logic [BD-1:0] centre);
        for (int a = 0; a < K*K; a++) begin
            @(posedge clk); #1;
            w_we = 1'b1; w_addr = 4'(a); w_data = (a == 4) ? centre : v;
        end
        @(posedge clk); #1 w_we = 1'b0;
    endtask

    task automatic send_col(input logic [K*BD-1:0] col);
        int t = 0;
        in_valid = 1'b1;
        in_col = col;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk("col_accepted", in_ready, 1);
        chk("shift_buffer", shift_buffer, 1);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic run_row(input int mode, input logic [1:0] s, input int pause_at, input int wwe_at, input int abort_at);
        int se;
        logic [BD-1:0] k8;
        logic [K*BD-1:0] col;
        longint e;
        se = (s == 2'd0) ? 1 : int'(s);
        @(posedge clk); #1 start = 1'b1; stride = s;
        @(posedge clk); #1 start = 1'b0; stride = 2'd0;
        for (int c = 0; c < IW; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_out_data", out_data, 0);
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_done", done, 0);
                expq.delete();
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            k8 = 8'(c);
            col = (mode == 0) ? {K{8'd1}} : (mode == 2) ? {K{8'd255}} : {K{k8}};
            case (mode)
                0: e = 9;
                1: e = 2*(c-1);
`ifdef CONV_RELU_EN
                2: e = 0;
`else
                2: e = -2295;
`endif
                default: e = 9*c - 9;
            endcase
            if (c >= K-1 && (c-(K-1)) % se == 0) expq.push_back(e);
            if (c == pause_at) begin
                out_ready = 1'b0;
                in_valid = 1'b1;
                in_col = col;
                repeat (5) begin
                    @(negedge clk);
                    chk("in_ready_paused", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
            if (c == wwe_at) begin
                w_we = 1'b1; w_addr = 4'd4; w_data = 8'd5;
            end
            send_col(col);
            w_we = 1'b0;
        end
        @(negedge clk); chk("done_early", done, 0);
        @(negedge clk); chk("done_pulse", done, 1);
        @(negedge clk); chk("done_after", done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stride = 2'd0; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_col = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        load_w(8'd1, 8'd1);
        run_row(0, 2'd1, -1, -1, -1);
        load_w(8'd0, 8'd2);
        run_row(1, 2'd2, -1, -1, -1);
        load_w(8'hFF, 8'hFF);
        run_row(2, 2'd0, -1, -1, -1);
        load_w(8'd1, 8'd1);
        run_row(3, 2'd1, 8, -1, -1);
        run_row(3, 2'd1, -1, -1, 7);
        run_row(3, 2'd1, -1, -1, -1);
        run_row(3, 2'd1, -1, 5, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 6);
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Parametrised successor to the line-fed 3x3 convolve controller.
- Streams one KERNEL-tall pixel column per handshake from the line buffers into a KERNELxKERNEL window register array, applying configurable horizontal stride.
- Each qualifying window is multiplied by a loadable signed weight kernel and accumulated; one result per window is emitted through a valid/ready output port.
- Sits between the line-buffer block (which it drives via shift_buffer) and the downstream activation/pooling stage.

Parameters:
- BIT_DEPTH, 8, pixel and weight width.
- KERNEL, 3, window height/width (legal 2..5).
- IMG_WIDTH, 16, columns per row (legal KERNEL..1024).
- ACC_WIDTH, 2*BIT_DEPTH+5, signed accumulator/output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one row; sampled in IDLE only.
- stride  in  2  horizontal stride; latched on start; 0 treated as 1.
- w_we  in  1  weight write strobe; honoured in IDLE only.
- w_addr  in  $clog2(KERNEL*KERNEL)  weight index, row-major; out-of-range ignored.
- w_data  in  BIT_DEPTH  signed weight.
- in_valid  in  1  column valid.
- in_col  in  KERNEL*BIT_DEPTH  unsigned pixels, row 0 in LSBs.
- in_ready  out  1  column accepted when in_valid&&in_ready.
- shift_buffer  out  1  equals in_valid&&in_ready (line-buffer advance).
- out_valid  out  1  result valid.
- out_data  out  ACC_WIDTH  signed window sum.
- out_ready  in  1  downstream accept.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  one-cycle pulse at end of row.

Behaviour:
- Reset: out_valid=0, out_data=0, done=0, busy=0, in_ready=0, window and col_cnt cleared, state IDLE. Weights are NOT reset (hold last written value; X after power-up).
- States: IDLE -> RUN on start (stride latched, col_cnt=0, window cleared). RUN -> DRAIN when column IMG_WIDTH-1 is accepted. DRAIN -> DONE when out_valid=0, or out_valid&&out_ready. DONE -> IDLE unconditionally; done=1 only in DONE.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- On accept: window shifts left one column; in_col enters the rightmost column; col_cnt increments.
- Window qualifies when accepted column index c >= KERNEL-1 and (c-(KERNEL-1)) mod stride_eff == 0.
- Qualifying accept: next cycle out_data = sum over i,j of pixel(i,j)*weight(i,j), using the post-shift window; out_valid=1. Latency is exactly 1 cycle.
- Arithmetic: pixel zero-extended to BIT_DEPTH+1 signed; weight signed; products sign-extended to ACC_WIDTH; no saturation (default width cannot overflow for KERNEL<=5).
- out_valid holds with out_data stable until out_ready. Simultaneous out_ready and a new qualifying accept produce back-to-back results with no bubble.
- Non-qualifying accept with out_ready=1 clears out_valid.
- start outside IDLE ignored; w_we outside IDLE ignored.
- Async rst mid-row aborts immediately; no done pulse.
- Outputs per row = floor((IMG_WIDTH-KERNEL)/stride_eff)+1.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: out_data is clamped to 0 when the sum is negative, combined with the result register (latency unchanged).
- Undefined: raw signed sum is output.

Test Plan:
- Reset then load all weights=1, stride=1, columns of pixels {1,1,1} x16 -> 14 outputs of 9, done pulse 1 cycle after the last out_valid/out_ready.
- Weights centre=2 and others 0, stride=2, column k pixels all =k -> outputs 2,6,10,...,26 (7 results) at c=2,4,...,14.
- Weights all -1, pixels 255, stride=0 -> 14 outputs of -2295. With CONV_RELU_EN -> 0.
- out_ready held low for 5 cycles mid-row -> in_ready=0, out_data stable, no column lost; stream resumes with correct values.
- Assert rst at column 7 -> all outputs 0 in the same cycle, no done; new start with the same weights works without reloading.
- w_we pulsed during RUN with w_data=5 -> weight unchanged and results identical to the no-write run.
